// File: rtl/clk_gate_sequencer.sv
// Purpose: sequences the core clock-gate enable: RUN -> DRAIN -> GATED -> WAKE -> RUN on wb_clk.
// Latency: gate_en is registered; a wake event seen through the SYNC_STAGES synchroniser reopens the clock one edge later.
// Backpressure: none; busy holds off gating in DRAIN, sleep_req low or any wake event aborts to RUN.
// Optional feature macro: GATE_DEBUG_HOLD_EN (enb_debug=1 holds the clock on and blocks sleep entry).
module clk_gate_sequencer #(
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 24
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             sleep_req,
    input  logic             busy,
    input  logic [2:0]       buttons,
    input  logic             timer_evt,
    input  logic             enb_debug,
    output logic             gate_en,
    output logic [1:0]       state,
    output logic             wake_pulse,
    output logic [2:0]       wake_cause,
    output logic [CNT_W-1:0] gated_cycles
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    state_t                        state_q;
    logic [SYNC_STAGES-1:0][2:0]   btn_sync;
    logic [SYNC_STAGES-1:0]        tmr_sync;
    logic [2:0]                    btn_prev;
    logic                          tmr_prev;
    logic [IDLE_W-1:0]             idle_cnt;
    logic [WAKE_W-1:0]             wake_cnt;
    logic                          armed;
    logic                          btn_evt;
    logic                          tmr_evt;
    logic [2:0]                    evt_bits;
    logic                          wake_any;
    logic                          debug_hold;

    assign state = state_q;

    // Bring the asynchronous pads into wb_clk and keep last synchronised values for edge detection.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            btn_sync <= '0;
            tmr_sync <= '0;
            btn_prev <= '0;
            tmr_prev <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], buttons};
            tmr_sync <= {tmr_sync[SYNC_STAGES-2:0], timer_evt};
            btn_prev <= btn_sync[SYNC_STAGES-1];
            tmr_prev <= tmr_sync[SYNC_STAGES-1];
        end
    end

    // Buttons wake on any change, the timer on a rising edge, debug on level.
    assign btn_evt  = |(btn_sync[SYNC_STAGES-1] ^ btn_prev);
    assign tmr_evt  = tmr_sync[SYNC_STAGES-1] & ~tmr_prev;
    assign evt_bits = {enb_debug, tmr_evt, btn_evt};
    assign wake_any = |evt_bits;

`ifdef GATE_DEBUG_HOLD_EN
    assign debug_hold = enb_debug;
`else
    assign debug_hold = 1'b0;
`endif

    // Sequencer FSM; every output is registered so gate_en never glitches from input logic.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q      <= ST_RUN;
            gate_en      <= 1'b1;
            wake_pulse   <= 1'b0;
            wake_cause   <= 3'b000;
            gated_cycles <= '0;
            idle_cnt     <= '0;
            wake_cnt     <= '0;
            armed        <= 1'b1;
        end else begin
            gate_en    <= 1'b1;
            wake_pulse <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (!sleep_req) begin
                        armed <= 1'b1;
                    end else if (armed && !debug_hold) begin
                        state_q    <= ST_DRAIN;
                        idle_cnt   <= '0;
                        wake_cause <= 3'b000;
                        armed      <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Abort wins over gating when both happen in one cycle.
                    if (!sleep_req || wake_any) begin
                        state_q    <= ST_RUN;
                        wake_cause <= wake_cause | evt_bits;
                    end else if (!busy && idle_cnt == IDLE_LAST) begin
                        state_q      <= ST_GATED;
                        gate_en      <= debug_hold;
                        gated_cycles <= '0;
                    end else if (busy) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_GATED: begin
                    if (gated_cycles != {CNT_W{1'b1}}) begin
                        gated_cycles <= gated_cycles + 1'b1;
                    end
                    if (wake_any) begin
                        state_q    <= ST_WAKE;
                        wake_cnt   <= '0;
                        wake_cause <= wake_cause | evt_bits;
                    end else begin
                        gate_en <= debug_hold;
                    end
                end
                ST_WAKE: begin
                    // Late events are recorded but do not stretch the wake window.
                    wake_cause <= wake_cause | evt_bits;
                    if (wake_cnt == WAKE_LAST) begin
                        state_q    <= ST_RUN;
                        wake_pulse <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gate_sequencer.sv
// Purpose: self-checking bench for clk_gate_sequencer against a cycle-level behavioural model.
// Latency: inputs driven on the falling edge, outputs sampled one falling edge after each rising edge.
// Backpressure: not applicable; the bench drives every input directly.
module tb_clk_gate_sequencer;

    localparam int IDLE = 8;
    localparam int WAKE = 4;
    localparam int SYNC = 2;
    localparam int CW   = 8;

    logic          wb_clk = 1'b0;
    logic          wb_rst = 1'b0;
    logic          sleep_req = 1'b0;
    logic          busy = 1'b0;
    logic [2:0]    buttons = 3'b000;
    logic          timer_evt = 1'b0;
    logic          enb_debug = 1'b0;
    logic          gate_en;
    logic [1:0]    state;
    logic          wake_pulse;
    logic [2:0]    wake_cause;
    logic [CW-1:0] gated_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    clk_gate_sequencer #(
        .IDLE_CYCLES(IDLE),
        .WAKE_CYCLES(WAKE),
        .SYNC_STAGES(SYNC),
        .CNT_W(CW)
    ) dut (
        .wb_clk(wb_clk),
        .wb_rst(wb_rst),
        .sleep_req(sleep_req),
        .busy(busy),
        .buttons(buttons),
        .timer_evt(timer_evt),
        .enb_debug(enb_debug),
        .gate_en(gate_en),
        .state(state),
        .wake_pulse(wake_pulse),
        .wake_cause(wake_cause),
        .gated_cycles(gated_cycles)
    );

    always #5 wb_clk = ~wb_clk;

    // ---------------- behavioural reference ----------------
    // Phases follow the published state numbering: 0 run, 1 drain, 2 gated, 3 wake.
    int       m_phase;
    bit       m_gate;
    bit       m_pulse;
    bit [2:0] m_cause;
    int       m_gated;
    int       m_quiet;
    int       m_woke;
    bit       m_armed;
    bit [2:0] btn_hist[$];
    bit       tmr_hist[$];

    function automatic void model_reset();
        m_phase = 0; m_gate = 1'b1; m_pulse = 1'b0; m_cause = 3'b000;
        m_gated = 0; m_quiet = 0; m_woke = 0; m_armed = 1'b1;
        btn_hist.delete();
        tmr_hist.delete();
        for (int i = 0; i <= SYNC; i++) begin
            btn_hist.push_back(3'b000);
            tmr_hist.push_back(1'b0);
        end
    endfunction

    // Advance the reference by one rising edge using the inputs currently driven.
    // History index k holds the raw value captured k+1 edges ago, so the synchronised
    // value is index SYNC-1 and its previous value is index SYNC.
    function automatic void model_eval();
        bit [2:0] ev;
        ev[0] = (btn_hist[SYNC-1] != btn_hist[SYNC]);
        ev[1] = tmr_hist[SYNC-1] && !tmr_hist[SYNC];
        ev[2] = enb_debug;
        btn_hist.push_front(buttons);
        void'(btn_hist.pop_back());
        tmr_hist.push_front(timer_evt);
        void'(tmr_hist.pop_back());
        m_pulse = 1'b0;
        case (m_phase)
            0: begin
                if (!sleep_req) m_armed = 1'b1;
                else if (m_armed) begin
                    m_phase = 1; m_quiet = 0; m_cause = 3'b000; m_armed = 1'b0;
                end
            end
            1: begin
                if (!sleep_req || ev != 3'b000) begin
                    m_phase = 0; m_cause |= ev;
                end else if (!busy && m_quiet == IDLE - 1) begin
                    m_phase = 2; m_gated = 0;
                end else begin
                    m_quiet = busy ? 0 : m_quiet + 1;
                end
            end
            2: begin
                if (m_gated < (1 << CW) - 1) m_gated++;
                if (ev != 3'b000) begin
                    m_phase = 3; m_woke = 0; m_cause |= ev;
                end
            end
            default: begin
                m_cause |= ev;
                m_woke++;
                if (m_woke == WAKE) begin
                    m_phase = 0; m_pulse = 1'b1;
                end
            end
        endcase
        m_gate = (m_phase != 2);
    endfunction

    function automatic logic [CW+6:0] dut_vec();
        return {gate_en, state, wake_pulse, wake_cause, gated_cycles};
    endfunction

    function automatic logic [CW+6:0] mdl_vec();
        logic [1:0]    ph;
        logic [CW-1:0] gc;
        ph = m_phase[1:0];
        gc = m_gated[CW-1:0];
        return {m_gate, ph, m_pulse, m_cause, gc};
    endfunction

    task automatic step();
        model_eval();
        @(posedge wb_clk);
        @(negedge wb_clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        wb_rst = 1'b0;
        repeat (3) @(negedge wb_clk);
        n_cmp++;
        if ({gate_en, state, wake_pulse, wake_cause, gated_cycles} !== {1'b1, 2'd0, 1'b0, 3'd0, {CW{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_values: got %h want %h", dut_vec(), {1'b1, 2'd0, 1'b0, 3'd0, {CW{1'b0}}});
        end
        wb_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_sleep_gate();
        sleep_req = 1'b0; busy = 1'b0;
        repeat (3) step();
        sleep_req = 1'b1;
        step();
        n_cmp++;
        if (state !== 2'd1 || gate_en !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_entry: state=%0d gate_en=%0b want 1/1", state, gate_en);
        end
        for (int i = 0; i < IDLE; i++) begin
            step();
            n_cmp++;
            if (state !== ((i == IDLE - 1) ? 2'd2 : 2'd1) || gate_en !== (i != IDLE - 1)) begin
                n_bad++;
                $display("FAIL drain_count[%0d]: state=%0d gate_en=%0b", i, state, gate_en);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL gated_hold[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if (gated_cycles !== CW'(20)) begin
            n_bad++;
            $display("FAIL gated_count: got %0d want 20", gated_cycles);
        end
    endtask

    task automatic test_button_wake();
        buttons = buttons ^ 3'b010;
        for (int i = 0; i <= SYNC; i++) begin
            step();
            n_cmp++;
            if (state !== ((i == SYNC) ? 2'd3 : 2'd2) || dut_vec() !== mdl_vec()) begin
                n_bad++;
                $display("FAIL button_sync[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
            end
        end
        n_cmp++;
        if (gated_cycles !== CW'(20 + SYNC + 1) || gate_en !== 1'b1) begin
            n_bad++;
            $display("FAIL button_gated_len: got %0d/%0b want %0d/1", gated_cycles, gate_en, 20 + SYNC + 1);
        end
        for (int i = 0; i < WAKE; i++) begin
            step();
            n_cmp++;
            if (wake_pulse !== (i == WAKE - 1) || state !== ((i == WAKE - 1) ? 2'd0 : 2'd3)) begin
                n_bad++;
                $display("FAIL wake_window[%0d]: pulse=%0b state=%0d", i, wake_pulse, state);
            end
        end
        step();
        n_cmp++;
        if (wake_pulse !== 1'b0 || wake_cause !== 3'b001 || dut_vec() !== mdl_vec()) begin
            n_bad++;
            $display("FAIL button_cause: pulse=%0b cause=%b want 0/001", wake_pulse, wake_cause);
        end
    endtask

    task automatic test_busy_restart();
        sleep_req = 1'b0;
        step();
        sleep_req = 1'b1;
        step();
        repeat (5) step();
        busy = 1'b1;
        step();
        busy = 1'b0;
        for (int i = 0; i < IDLE; i++) begin
            step();
            n_cmp++;
            if (gate_en !== (i != IDLE - 1) || state !== ((i == IDLE - 1) ? 2'd2 : 2'd1)) begin
                n_bad++;
                $display("FAIL busy_restart[%0d]: state=%0d gate_en=%0b", i, state, gate_en);
            end
        end
        enb_debug = 1'b1;
        step();
        enb_debug = 1'b0;
        n_cmp++;
        if (state !== 2'd3 || wake_cause !== 3'b100 || gate_en !== 1'b1) begin
            n_bad++;
            $display("FAIL debug_wake: state=%0d cause=%b gate_en=%0b", state, wake_cause, gate_en);
        end
        repeat (WAKE) step();
        n_cmp++;
        if (dut_vec() !== mdl_vec() || state !== 2'd0) begin
            n_bad++;
            $display("FAIL debug_wake_end: dut=%h model=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_timer_abort();
        int pulses;
        pulses = 0;
        sleep_req = 1'b0;
        step();
        sleep_req = 1'b1;
        step();
        repeat (IDLE - 1 - SYNC) begin step(); pulses += wake_pulse; end
        timer_evt = 1'b1;
        repeat (SYNC + 1) begin step(); pulses += wake_pulse; end
        n_cmp++;
        if (state !== 2'd0 || gate_en !== 1'b1 || wake_cause !== 3'b010) begin
            n_bad++;
            $display("FAIL timer_abort: state=%0d gate_en=%0b cause=%b want 0/1/010", state, gate_en, wake_cause);
        end
        repeat (4) begin step(); pulses += wake_pulse; end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL timer_abort_pulse: saw %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_rearm_and_saturate();
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (state !== 2'd0) begin
                n_bad++;
                $display("FAIL rearm_hold[%0d]: state=%0d want 0", i, state);
            end
        end
        sleep_req = 1'b0;
        step();
        sleep_req = 1'b1;
        step();
        n_cmp++;
        if (state !== 2'd1) begin
            n_bad++;
            $display("FAIL rearm_entry: state=%0d want 1", state);
        end
        repeat (IDLE + 300) step();
        n_cmp++;
        if (state !== 2'd2 || gated_cycles !== {CW{1'b1}} || dut_vec() !== mdl_vec()) begin
            n_bad++;
            $display("FAIL saturate: state=%0d gated=%0d want 2/%0d", state, gated_cycles, (1 << CW) - 1);
        end
    endtask

    task automatic test_reset_mid_gated();
        #2 wb_rst = 1'b0;
        #1;
        n_cmp++;
        if ({gate_en, state, wake_pulse, wake_cause, gated_cycles} !== {1'b1, 2'd0, 1'b0, 3'd0, {CW{1'b0}}}) begin
            n_bad++;
            $display("FAIL async_reset: got %h", dut_vec());
        end
        sleep_req = 1'b0;
        timer_evt = 1'b0;
        @(negedge wb_clk);
        wb_rst = 1'b1;
        model_reset();
        step();
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
            n_bad++;
            $display("FAIL post_reset: dut=%h model=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19, 0) == 0) sleep_req = ~sleep_req;
            busy = ($urandom_range(5, 0) == 0);
            if ($urandom_range(59, 0) == 0) buttons[$urandom_range(2, 0)] ^= 1'b1;
            if ($urandom_range(39, 0) == 0) timer_evt = ~timer_evt;
            enb_debug = ($urandom_range(79, 0) == 0);
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_bad++;
                if (errs < 10) $display("FAIL random[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
                errs++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_sleep_gate();
        test_button_wake();
        test_busy_restart();
        test_timer_abort();
        test_rearm_and_saturate();
        test_reset_mid_gated();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
